// File: rtl/c7bicu_resp.sv
// I-cache responder for IFU fetches: ack, 64-bit block fetch over req/gnt/rvalid, 32-bit word return.
// Define C7BICU_LINEBUF_EN to add a one-entry block buffer that serves repeat fetches without memory traffic.
module c7bicu_resp #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifu_icu_req_ic1,
  input  logic [ADDR_W-1:0] ifu_icu_addr_ic1,
  output logic              icu_ifu_ack_ic1,
  output logic              icu_ifu_data_valid_ic2,
  output logic [31:0]       icu_ifu_data_ic2,
  input  logic              icu_inv,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MREQ  = 2'd1,
    S_MWAIT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-3:0]   addr_q;   // fetch address bits [ADDR_W-1:2]
  logic                hit;
  logic [31:0]         buf_word;
  logic                unused_addr_lsb;

  // valid/ready: ack pulses for one cycle when req is high and the responder is IDLE;
  // the address is taken on that cycle and exactly one data_valid pulse follows, in order.
  assign icu_ifu_ack_ic1 = ifu_icu_req_ic1 && (state == S_IDLE);
  assign mem_addr        = {addr_q[ADDR_W-3:1], 3'b000};
  assign fsm_state       = state;
  assign unused_addr_lsb = ^ifu_icu_addr_ic1[1:0];

`ifdef C7BICU_LINEBUF_EN
  logic              buf_valid;
  logic [ADDR_W-4:0] buf_tag;
  logic [63:0]       buf_data;

  assign hit      = buf_valid && (buf_tag == ifu_icu_addr_ic1[ADDR_W-1:3]);
  assign buf_word = ifu_icu_addr_ic1[2] ? buf_data[63:32] : buf_data[31:0];

  // A fill racing an invalidate keeps the data but leaves the entry invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if ((state == S_MWAIT) && mem_rvalid) begin
      buf_valid <= !icu_inv;
      buf_tag   <= addr_q[ADDR_W-3:1];
      buf_data  <= mem_rdata;
    end else if (icu_inv) begin
      buf_valid <= 1'b0;
    end
  end
`else
  logic unused_inv;

  assign hit        = 1'b0;
  assign buf_word   = 32'd0;
  assign unused_inv = icu_inv;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= S_IDLE;
      addr_q                 <= '0;
      mem_req                <= 1'b0;
      icu_ifu_data_valid_ic2 <= 1'b0;
      icu_ifu_data_ic2       <= 32'd0;
    end else begin
      icu_ifu_data_valid_ic2 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ifu_icu_req_ic1) begin
            addr_q <= ifu_icu_addr_ic1[ADDR_W-1:2];
            if (hit) begin
              icu_ifu_data_ic2       <= buf_word;
              icu_ifu_data_valid_ic2 <= 1'b1;
              state                  <= S_RESP;
            end else begin
              mem_req <= 1'b1;
              state   <= S_MREQ;
            end
          end
        end
        S_MREQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_MWAIT;
          end
        end
        S_MWAIT: begin
          if (mem_rvalid) begin
            icu_ifu_data_ic2       <= addr_q[0] ? mem_rdata[63:32] : mem_rdata[31:0];
            icu_ifu_data_valid_ic2 <= 1'b1;
            state                  <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
